seg14_scroll_mux: RTL

Parametrised multiplexed driver for a common-select 14-segment display bank. It holds a writable character buffer and decodes 6-bit character codes through the team's standard 14-segment glyph table. It time-multiplexes the digits with a programmable dwell and can scroll the message across the bank. It replaces the fixed-text, fixed-12-digit display blocks and sits between the user-area logic that writes messages and the display pads.

---
 rtl/seg14_scroll_mux.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seg14_scroll_mux.sv
// rtl/seg14_scroll_mux.sv - multiplexed, scrolling 14-segment display bank driver
module seg14_scroll_mux #(
    parameter int NUM_DIGITS    = 12,
    parameter int MSG_LEN       = 16,
    parameter int DWELL         = 1,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
    input  logic [5:0]                  wr_char,
    input  logic [$clog2(MSG_LEN):0]    msg_len,
    input  logic                        scroll_en,
    input  logic                        blank,
    output logic [NUM_DIGITS-1:0]       sel,
    output logic [13:0]                 segm,
    output logic                        frame_start
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(DWELL + 1);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);
    // ofs + digit index stays below 2*MSG_LEN, one spare bit keeps the sum exact
    localparam int SW = LW + 1;

    localparam logic [5:0] CH_SPACE = 6'd37;

    logic [5:0]    buffer [MSG_LEN];
    logic [CW-1:0] dwell_cnt;
    logic [DW-1:0] digit_idx;
    logic [FW-1:0] frame_cnt;
    logic [AW-1:0] ofs;

    logic [LW-1:0] eff_len;
    logic          dwell_wrap;
    logic          digit_wrap;
    logic          frame_wrap;
    logic [SW-1:0] sum;
    logic [AW-1:0] rd_idx;
    logic [5:0]    disp_char;

    // Glyph table: bit 13..6 = a,b,c,d,e,f,g1,g2; bit 5..0 = h,i,j,k,l,m
    // (upper-left diag, upper centre, upper-right diag, lower-right diag,
    // lower centre, lower-left diag). Unassigned codes render as space.
    function automatic logic [13:0] glyph_of(input logic [5:0] c);
        logic [13:0] g;
        case (c)
            6'd0:    g = 14'b11111100_001001;
            6'd1:    g = 14'b01100000_001000;
            6'd2:    g = 14'b11011011_000000;
            6'd3:    g = 14'b11110001_000000;
            6'd4:    g = 14'b01100111_000000;
            6'd5:    g = 14'b10110111_000000;
            6'd6:    g = 14'b10111111_000000;
            6'd7:    g = 14'b11100000_000000;
            6'd8:    g = 14'b11111111_000000;
            6'd9:    g = 14'b11110111_000000;
            6'd10:   g = 14'b11101111_000000; // A
            6'd11:   g = 14'b11110001_010010; // B
            6'd12:   g = 14'b10011100_000000; // C
            6'd13:   g = 14'b11110000_010010; // D
            6'd14:   g = 14'b10011110_000000; // E
            6'd15:   g = 14'b10001110_000000; // F
            6'd16:   g = 14'b10111101_000000; // G
            6'd17:   g = 14'b01101111_000000; // H
            6'd18:   g = 14'b10010000_010010; // I
            6'd19:   g = 14'b01111000_000000; // J
            6'd20:   g = 14'b00001110_001100; // K
            6'd21:   g = 14'b00011100_000000; // L
            6'd22:   g = 14'b01101100_101000; // M
            6'd23:   g = 14'b01101100_100100; // N
            6'd24:   g = 14'b11111100_000000; // O
            6'd25:   g = 14'b11001111_000000; // P
            6'd26:   g = 14'b11111100_000100; // Q
            6'd27:   g = 14'b11001111_000100; // R
            6'd28:   g = 14'b10110111_000000; // S
            6'd29:   g = 14'b10000000_010010; // T
            6'd30:   g = 14'b01111100_000000; // U
            6'd31:   g = 14'b00001100_001001; // V
            6'd32:   g = 14'b01101100_000101; // W
            6'd33:   g = 14'b00000000_101101; // X
            6'd34:   g = 14'b00000000_101010; // Y
            6'd35:   g = 14'b10010000_001001; // Z
            6'd36:   g = 14'b11101100_100100; // N-tilde: N with a top bar
            default: g = 14'b00000000_000000; // space and unused codes
        endcase
        return g;
    endfunction

    // Clamp the requested message length to the physical buffer depth
    always_comb begin
        eff_len = msg_len;
        if (msg_len > LW'(MSG_LEN)) begin
            eff_len = LW'(MSG_LEN);
        end
    end

    assign dwell_wrap = (dwell_cnt == CW'(DWELL - 1));
    assign digit_wrap = dwell_wrap && (digit_idx == DW'(NUM_DIGITS - 1));
    assign frame_wrap = digit_wrap && (frame_cnt == FW'(SCROLL_FRAMES - 1));

    // Character buffer: cleared to space on reset, out-of-range writes dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buffer[i] <= CH_SPACE;
            end
        end else if (wr_en && (LW'(wr_addr) < LW'(MSG_LEN))) begin
            buffer[wr_addr] <= wr_char;
        end
    end

    // Free-running scan: dwell -> digit -> frame, each advancing on the wrap of the one below
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_wrap ? '0 : dwell_cnt + CW'(1);
            if (dwell_wrap) begin
                digit_idx <= digit_wrap ? '0 : digit_idx + DW'(1);
            end
            if (digit_wrap) begin
                frame_cnt <= frame_wrap ? '0 : frame_cnt + FW'(1);
            end
        end
    end

    // Scroll offset: steps only as digit_idx returns to 0, so a frame never mixes offsets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofs <= '0;
        end else if (!scroll_en || (LW'(ofs) >= eff_len)) begin
            ofs <= '0;
        end else if (frame_wrap) begin
            ofs <= ((LW'(ofs) + LW'(1)) >= eff_len) ? '0 : ofs + AW'(1);
        end
    end

    // Pick the character for the digit being scanned this cycle
    always_comb begin
        sum       = '0;
        rd_idx    = '0;
        disp_char = CH_SPACE;
        if (eff_len != '0) begin
            if (scroll_en) begin
                sum    = SW'(ofs) + SW'(digit_idx);
                rd_idx = AW'(sum % SW'(eff_len));
            end else begin
                rd_idx = AW'(digit_idx);
            end
            if (scroll_en || (LW'(digit_idx) < eff_len)) begin
                disp_char = buffer[rd_idx];
            end
        end
    end

    // Registered pad drive; frame_start marks the scan position, so it keeps ticking while blanked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '0;
            segm        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (digit_idx == '0) && (dwell_cnt == '0);
            if (blank) begin
                sel  <= '0;
                segm <= '0;
            end else begin
                sel  <= NUM_DIGITS'(1) << digit_idx;
                segm <= glyph_of(disp_char);
            end
        end
    end

endmodule
